sobel_frame_filter: RTL
=======================

// Module: sobel_frame_filter
// PURPOSE
//  Frame-level Sobel stage: on start, scans a grayscale frame held in the source dual-port BRAM,
//  fetches each pixel's 3x3 neighbourhood, computes |Gx|+|Gy| saturated to 8 bits, and writes
//  the result at the same address into the destination BRAM. Consumes the loader's frame BRAM
//  (read port) and produces the edge-map BRAM (write port); controlled by the top-level sequencer.
// PARAMETERS
//  IMG_W_LOG2  6    log2 frame width (IMG_W = 64)
//  IMG_H_LOG2  6    log2 frame height (IMG_H = 64)
//  DATA_WIDTH  8    pixel width; the design supports only 8
//  ADDR_WIDTH  12   = IMG_W_LOG2 + IMG_H_LOG2; address = {y, x}
// PORTS
//  clk       in   1           rising-edge clock
//  reset_n   in   1           asynchronous, active-low reset
//  start     in   1           one-cycle request; sampled only in IDLE
//  busy      out  1           high from the cycle after start acceptance until done
//  done      out  1           one-cycle pulse after the final destination write
//  src_addr  out  ADDR_WIDTH  source BRAM read address
//  src_ce    out  1           source chip enable
//  src_we    out  1           source write enable, constant 0
//  src_q     in   DATA_WIDTH  source read data; valid the cycle after src_ce=1, held while ce=0
//  dst_addr  out  ADDR_WIDTH  destination BRAM address
//  dst_ce    out  1           destination chip enable
//  dst_we    out  1           destination write enable
//  dst_d     out  DATA_WIDTH  destination write data
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, src_ce, dst_ce, dst_we = 0; src_addr, dst_addr, dst_d = 0.
//  - FSM: IDLE -> (start) -> PIXEL -> FETCH -> CALC -> WRITE -> PIXEL ... -> DONE -> IDLE.
//  - Scan order is raster: x increments fastest, then y. Both wrap at IMG_W-1 / IMG_H-1.
//  - PIXEL: 1 cycle. On a border pixel (x=0, x=IMG_W-1, y=0 or y=IMG_H-1), PIXEL performs
//    the write itself: dst_ce=dst_we=1, dst_d=0. The FSM then advances without fetching.
//    On an interior pixel, PIXEL does nothing and the FSM goes to FETCH.
//  - FETCH: counter k runs 0..9, one cycle per value (10 cycles).
//    - For k<9: src_ce=1 and src_addr={y+dy, x+dx}, where dy=k/3-1 and dx=k%3-1.
//    - For k>=1: src_q is captured into win[k-1].
//  - CALC: 1 cycle. Registers the gradients from win[0..8] (row-major, top-left first):
//    - Gx=(w2+2w5+w8)-(w0+2w3+w6) and Gy=(w6+2w7+w8)-(w0+2w1+w2), both 11-bit signed.
//    - mag=|Gx|+|Gy|, 12-bit unsigned; dst_d=(mag>255)?255:mag.
//  - WRITE: 1 cycle with dst_ce=dst_we=1 and dst_addr={y,x}. Outside write cycles dst_ce=dst_we=0.
//  - Cycle cost: 1 cycle per border pixel and 12 per interior pixel, so 46380 cycles per 64x64
//    frame. This is followed by DONE (1 cycle, done=1, busy=0) and then IDLE.
//  - start while busy or in DONE is ignored; no queueing.
//  - src_ce=0 in every state except FETCH with k<9. The block never reads and writes the same
//    BRAM; source and destination are distinct memories.
//  - Reset asserted mid-frame: immediate return to IDLE with reset outputs. Destination contents
//    are undefined; the next start reprocesses the whole frame.
//  - Saturation is the only overflow rule; no intermediate term is truncated.
// STRUCTURE
//  - Shared package sobel_pkg holds:
//    - state encoding localparams (IDLE, PIXEL, FETCH, CALC, WRITE, DONE);
//    - window index constants and the 8-bit saturation limit 255;
//    - ADDR_WIDTH derivation helpers.
//  - One sub-module, sobel_kernel3x3: combinational 9-pixel -> saturated 8-bit magnitude, with
//    the CALC register held in the parent. Everything else lives in sobel_frame_filter.
// TESTING
//  - Uniform frame (all 0x80), start -> every dst location 0; done after exactly 46381 cycles
//    counted from the start-sampling edge.
//  - Vertical step (x<32 -> 0, x>=32 -> 255) -> interior x=31 and x=32 read 255 (Gx=1020
//    saturated); all other locations 0.
//  - Horizontal ramp (pixel = x) -> every interior pixel 8, border pixels 0.
//  - Single bright pixel 255 at (10,10) -> (9,10)=255, (11,10)=255, (10,9)=255, (10,11)=255,
//    (9,9)=255; (12,10)=0.
//  - Second start pulse in mid-frame -> ignored; busy stays high, exactly one done, output
//    unchanged vs single start.
//  - reset_n low for 2 cycles at cycle 5000 -> all outputs 0 asynchronously. A fresh start then
//    yields a full correct frame and done at +46381 cycles.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel frame filter: FSM states, window tap layout,
// saturation limit and address-width derivation.
package sobel_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPixel,
    StFetch,
    StCalc,
    StWrite,
    StDone
  } state_e;

  // k runs 0..FetchLast: reads are issued on 0..8, data lands on 1..9.
  localparam int unsigned FetchLast = 9;
  localparam int unsigned CenterTap = 4;

  // The centre tap has zero weight in both kernels, so only the 8 neighbours are kept.
  localparam int unsigned NbCount = 8;
  localparam int unsigned NbTl = 0;
  localparam int unsigned NbT  = 1;
  localparam int unsigned NbTr = 2;
  localparam int unsigned NbL  = 3;
  localparam int unsigned NbR  = 4;
  localparam int unsigned NbBl = 5;
  localparam int unsigned NbB  = 6;
  localparam int unsigned NbBr = 7;

  localparam logic [7:0] SatMax = 8'd255;

  function automatic int unsigned addr_width(input int unsigned w_log2,
                                             input int unsigned h_log2);
    return w_log2 + h_log2;
  endfunction

endpackage

// File: rtl/sobel_kernel3x3.sv
// Combinational Sobel magnitude: |Gx|+|Gy| of a 3x3 neighbourhood, saturated to 8 bits.
module sobel_kernel3x3
  import sobel_pkg::*;
(
  input  logic [NbCount-1:0][7:0] nbr,
  output logic [7:0]              mag
);

  logic signed [10:0] gx, gy;
  logic        [10:0] ax, ay;
  logic        [11:0] sum;

  function automatic logic signed [10:0] px(input logic [7:0] p);
    return signed'({3'b000, p});
  endfunction

  always_comb begin
    gx  = (px(nbr[NbTr]) + (px(nbr[NbR]) <<< 1) + px(nbr[NbBr]))
        - (px(nbr[NbTl]) + (px(nbr[NbL]) <<< 1) + px(nbr[NbBl]));
    gy  = (px(nbr[NbBl]) + (px(nbr[NbB]) <<< 1) + px(nbr[NbBr]))
        - (px(nbr[NbTl]) + (px(nbr[NbT]) <<< 1) + px(nbr[NbTr]));
    ax  = gx[10] ? -gx : gx;
    ay  = gy[10] ? -gy : gy;
    sum = {1'b0, ax} + {1'b0, ay};
    mag = (sum > 12'd255) ? SatMax : sum[7:0];
  end

endmodule

// File: rtl/sobel_frame_filter.sv
// Frame-level Sobel stage: raster-scans the source BRAM, fetches each interior pixel's 3x3
// neighbourhood, and writes the saturated edge magnitude (0 on the border) to the destination.
module sobel_frame_filter
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W_LOG2 = 6,
  parameter int unsigned IMG_H_LOG2 = 6,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = addr_width(IMG_W_LOG2, IMG_H_LOG2)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] src_addr,
  output logic                  src_ce,
  output logic                  src_we,
  input  logic [DATA_WIDTH-1:0] src_q,
  output logic [ADDR_WIDTH-1:0] dst_addr,
  output logic                  dst_ce,
  output logic                  dst_we,
  output logic [DATA_WIDTH-1:0] dst_d
);

  localparam logic [IMG_W_LOG2-1:0] XMax = '1;
  localparam logic [IMG_H_LOG2-1:0] YMax = '1;

  state_e                    state_q, state_d;
  logic [IMG_W_LOG2-1:0]     x_q, next_x, src_x;
  logic [IMG_H_LOG2-1:0]     y_q, next_y, src_y;
  logic [3:0]                k_q;
  logic [1:0]                k_row, k_col;
  logic [NbCount-1:0][7:0]   nbr_q;
  logic [7:0]                mag_q, kernel_mag;
  logic                      last_pixel, next_border, advance;

  assign next_x      = x_q + 1'b1;
  assign next_y      = (x_q == XMax) ? y_q + 1'b1 : y_q;
  assign last_pixel  = (x_q == XMax) && (y_q == YMax);
  assign next_border = (next_x == '0) || (next_x == XMax) || (next_y == '0) || (next_y == YMax);
  assign advance     = (state_q == StPixel) || (state_q == StWrite);

  sobel_kernel3x3 u_kernel (
    .nbr (nbr_q),
    .mag (kernel_mag)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      k_q     <= '0;
      nbr_q   <= '0;
      mag_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && start) begin
        x_q <= '0;
        y_q <= '0;
      end else if (advance) begin
        x_q <= next_x;
        y_q <= next_y;
      end
      if (state_q == StFetch) begin
        k_q <= (k_q == 4'(FetchLast)) ? 4'd0 : k_q + 4'd1;
        // Shift in the arriving tap, skipping the centre; oldest tap ends at index 0.
        if (k_q != 4'd0 && k_q != 4'(CenterTap + 1)) begin
          nbr_q <= {src_q, nbr_q[NbCount-1:1]};
        end
      end
      if (state_q == StCalc) mag_q <= kernel_mag;
    end
  end

  // Interior pixels never idle in PIXEL: the border test for the next pixel is made on the
  // transition out of the current one, so an interior pixel costs FETCH+CALC+WRITE = 12.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:           if (start) state_d = StPixel;
      StPixel, StWrite: begin
        if (last_pixel)       state_d = StDone;
        else if (next_border) state_d = StPixel;
        else                  state_d = StFetch;
      end
      StFetch:          if (k_q == 4'(FetchLast)) state_d = StCalc;
      StCalc:           state_d = StWrite;
      StDone:           state_d = StIdle;
      default:          state_d = StIdle;
    endcase
  end

  assign k_row  = 2'(k_q / 4'd3);
  assign k_col  = 2'(k_q % 4'd3);
  assign src_y  = y_q + IMG_H_LOG2'(k_row) - IMG_H_LOG2'(1);
  assign src_x  = x_q + IMG_W_LOG2'(k_col) - IMG_W_LOG2'(1);
  assign src_we = 1'b0;

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    src_ce   = 1'b0;
    src_addr = '0;
    dst_ce   = 1'b0;
    dst_we   = 1'b0;
    dst_addr = '0;
    dst_d    = '0;
    unique case (state_q)
      StPixel: begin
        busy     = 1'b1;
        dst_ce   = 1'b1;
        dst_we   = 1'b1;
        dst_addr = {y_q, x_q};
      end
      StFetch: begin
        busy = 1'b1;
        if (k_q != 4'(FetchLast)) begin
          src_ce   = 1'b1;
          src_addr = {src_y, src_x};
        end
      end
      StCalc:  busy = 1'b1;
      StWrite: begin
        busy     = 1'b1;
        dst_ce   = 1'b1;
        dst_we   = 1'b1;
        dst_addr = {y_q, x_q};
        dst_d    = mag_q;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

endmodule
